// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock-ratio monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    MEASURE   = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } mon_state_e;

  localparam int unsigned DEF_WINDOW       = 1000;
  localparam int unsigned DEF_DIV          = 5;
  localparam int unsigned DEF_TOL          = 2;
  localparam int unsigned DEF_GOOD_WINDOWS = 4;
  localparam int unsigned DEF_LOCK_STABLE  = 256;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, with an optional
// registered rising-edge detect one flop further down.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic s1, s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d_i;
      s2 <= s1;
    end
  end

  assign level_o = s2;

  if (EDGE_EN) begin : g_edge
    logic s3;
    always_ff @(posedge clk_i) begin
      if (rst_i) s3 <= RST_VAL;
      else       s3 <= s2;
    end
    assign edge_o = s2 & ~s3;
  end else begin : g_no_edge
    assign edge_o = 1'b0;
  end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Qualifies the divided pixel clock against the serializer clock: debounces
// PLL lock, counts sample edges per window, gates downstream reset and flags drift.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned WINDOW       = DEF_WINDOW,
  parameter int unsigned DIV          = DEF_DIV,
  parameter int unsigned TOL          = DEF_TOL,
  parameter int unsigned GOOD_WINDOWS = DEF_GOOD_WINDOWS,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  localparam int unsigned CW          = $clog2(WINDOW + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lock_i,
  input  logic          sample_i,
  input  logic          clear_i,
  output logic          rst_o,
  output logic          ok_o,
  output logic          fault_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned WW  = $clog2(WINDOW);
  localparam int unsigned LW  = $clog2(LOCK_STABLE);
  localparam int unsigned GW  = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned EXP = WINDOW / DIV;
  // Lower bound clamps at zero so a large TOL cannot underflow.
  localparam int unsigned LO  = (EXP > TOL) ? (EXP - TOL) : 0;
  localparam int unsigned HI  = EXP + TOL;

  mon_state_e    state, state_n;
  logic [LW-1:0] lock_cnt, lock_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [CW-1:0] edge_cnt, edge_n, edge_fin;
  logic [GW-1:0] good_cnt, good_n;
  logic [CW-1:0] count_n;
  logic          fault_n;
  logic          lock_s, smp_edge;
  logic          win_last, lock_last, good_last, pass;

  sync_edge_detect #(.RST_VAL(1'b0), .EDGE_EN(1'b0)) u_lock_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (lock_i),
    .level_o (lock_s),
    .edge_o  ()
  );

  sync_edge_detect #(.RST_VAL(1'b0), .EDGE_EN(1'b1)) u_smp_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (sample_i),
    .level_o (),
    .edge_o  (smp_edge)
  );

  // Edge on the closing cycle still lands in the window; counter saturates.
  assign edge_fin  = (smp_edge && (edge_cnt != {CW{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;
  assign pass      = (32'(edge_fin) >= LO) && (32'(edge_fin) <= HI);
  assign win_last  = (win_cnt == WW'(WINDOW - 1));
  assign lock_last = (lock_cnt == LW'(LOCK_STABLE - 1));
  assign good_last = ((32'(good_cnt) + 32'd1) == GOOD_WINDOWS);

  always_comb begin
    state_n = state;
    lock_n  = lock_cnt;
    win_n   = win_cnt;
    edge_n  = edge_cnt;
    good_n  = good_cnt;
    count_n = count_o;
    fault_n = fault_o;
    // Lowest priority: any fault raised below overrides the clear.
    if (clear_i) fault_n = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        win_n  = '0;
        edge_n = '0;
        good_n = '0;
        if (!lock_s)        lock_n = '0;
        else if (lock_last) begin
          lock_n  = '0;
          state_n = MEASURE;
        end else            lock_n = lock_cnt + 1'b1;
      end
      MEASURE, RUN: begin
        lock_n = '0;
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          win_n   = '0;
          edge_n  = '0;
          good_n  = '0;
          if (state == RUN) fault_n = 1'b1;
        end else if (win_last) begin
          win_n   = '0;
          edge_n  = '0;
          count_n = edge_fin;
          if (state == MEASURE) begin
            if (pass) begin
              good_n = good_cnt + 1'b1;
              if (good_last) state_n = RUN;
            end else begin
              good_n = '0;
            end
          end else if (!pass) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end
        end else begin
          win_n  = win_cnt + 1'b1;
          edge_n = edge_fin;
        end
      end
      FAULT: begin
        lock_n = '0;
        win_n  = '0;
        edge_n = '0;
        good_n = '0;
        if (clear_i) state_n = WAIT_LOCK;
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      good_cnt <= '0;
      count_o  <= '0;
      fault_o  <= 1'b0;
      rst_o    <= 1'b1;
      ok_o     <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_n;
      win_cnt  <= win_n;
      edge_cnt <= edge_n;
      good_cnt <= good_n;
      count_o  <= count_n;
      fault_o  <= fault_n;
      // Registered from the current state, so they trail entry to RUN by a cycle.
      rst_o    <= (state != RUN);
      ok_o     <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor at default parameters.
module tb_clk_ratio_monitor;

  localparam int EXP = 1000 / 5;
  localparam int TOL = 2;
  localparam int M_MEAS = 0, M_RUN = 1, M_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst_i, lock_i, sample_i, clear_i;
  logic       rst_o, ok_o, fault_o;
  logic [9:0] count_o;

  always #5 clk = ~clk;

  clk_ratio_monitor dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .lock_i   (lock_i),
    .sample_i (sample_i),
    .clear_i  (clear_i),
    .rst_o    (rst_o),
    .ok_o     (ok_o),
    .fault_o  (fault_o),
    .count_o  (count_o)
  );

  typedef struct {
    int cnt;
    bit fault;
    bit rst;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    cur_rst, cur_fault;
  int    m_state, m_good;
  bit    m_fault;

  // Expected outcome of one full window of n edges, from the qualification rules.
  task automatic model_window(input int n, output item_t it);
    bit pass;
    pass = (n >= EXP - TOL) && (n <= EXP + TOL);
    if (m_state == M_MEAS) begin
      if (pass) begin
        m_good++;
        if (m_good == 4) m_state = M_RUN;
      end else m_good = 0;
    end else if (m_state == M_RUN && !pass) begin
      m_state = M_FAULT;
      m_fault = 1'b1;
    end
    it.cnt   = n;
    it.fault = m_fault;
    it.rst   = (m_state != M_RUN);
  endtask

  // Drives len cycles of sample_i (n rises, one every per cycles), checks
  // outputs each cycle and retires the previous window's entry on cycle 1.
  task automatic drive(input int n, input int per, input int len, input bit push);
    item_t it, nx;
    bit    have;
    have = 1'b0;
    for (int i = 0; i < len; i++) begin
      sample_i = ((i / per) < n) && ((i % per) < (per / 2));
      @(negedge clk);
      if (i == 1 && sb.size() > 0) begin
        it = sb.pop_front();
        have = 1'b1;
        cur_fault = it.fault;
        n_tests++;
        if (count_o !== 10'(it.cnt)) begin
          n_fail++;
          $display("FAIL count_o: got %0d want %0d at %0t", count_o, it.cnt, $time);
        end
      end
      if (i == 2 && have) cur_rst = it.rst;
      n_tests++;
      if (rst_o !== cur_rst || ok_o !== !cur_rst || fault_o !== cur_fault) begin
        n_fail++;
        $display("FAIL outputs rst/ok/fault: got %b/%b/%b want %b/%b/%b at %0t",
                 rst_o, ok_o, fault_o, cur_rst, !cur_rst, cur_fault, $time);
      end
    end
    sample_i = 1'b0;
    if (push) begin
      model_window(n, nx);
      sb.push_back(nx);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; lock_i = 1'b0; sample_i = 1'b0; clear_i = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    cur_rst = 1'b1; cur_fault = 1'b0;
    m_state = M_MEAS; m_good = 0; m_fault = 1'b0;
  endtask

  // Lock rises now; the first window's first sample slot follows 256 cycles later.
  task automatic lock_start();
    lock_i = 1'b1;
    drive(0, 1, 256, 1'b0);
  endtask

  task automatic qualify();
    repeat (4) drive(200, 5, 1000, 1'b1);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; lock_i = 1'b1; sample_i = 1'b1; clear_i = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (rst_o !== 1'b1 || ok_o !== 1'b0 || fault_o !== 1'b0 || count_o !== 10'd0) begin
      n_fail++;
      $display("FAIL reset values: got rst=%b ok=%b fault=%b count=%0d want 1/0/0/0",
               rst_o, ok_o, fault_o, count_o);
    end
    do_reset();
    drive(0, 1, 20, 1'b0);
  endtask

  task automatic test_nominal();
    do_reset();
    lock_start();
    qualify();
    drive(200, 5, 1000, 1'b1);
    drive(0, 1, 3, 1'b0);
  endtask

  task automatic test_lock_glitch();
    do_reset();
    lock_i = 1'b1;
    drive(0, 1, 202, 1'b0);
    lock_i = 1'b0;
    drive(0, 1, 1, 1'b0);
    lock_i = 1'b1;
    drive(0, 1, 256, 1'b0);
    qualify();
    drive(0, 1, 3, 1'b0);
  endtask

  task automatic test_tolerance();
    int cnts[13] = '{250, 198, 202, 200, 197, 202, 198, 200, 203, 198, 202, 200, 200};
    do_reset();
    lock_start();
    foreach (cnts[k]) drive(cnts[k], (cnts[k] > 200) ? 4 : 5, 1000, 1'b1);
    drive(0, 1, 3, 1'b0);
  endtask

  task automatic test_drift();
    do_reset();
    lock_start();
    qualify();
    drive(166, 6, 1000, 1'b1);
    drive(0, 1, 6, 1'b0);
    clear_i = 1'b1;
    cur_fault = 1'b0;
    drive(0, 1, 1, 1'b0);
    clear_i = 1'b0;
    drive(0, 1, 254, 1'b0);
    m_state = M_MEAS; m_good = 0; m_fault = 1'b0;
    qualify();
    drive(0, 1, 3, 1'b0);
  endtask

  task automatic test_lockloss_clear();
    do_reset();
    lock_start();
    qualify();
    drive(0, 1, 3, 1'b0);
    lock_i = 1'b0;
    drive(0, 1, 2, 1'b0);
    clear_i = 1'b1;
    cur_fault = 1'b1;
    drive(0, 1, 1, 1'b0);
    clear_i = 1'b0;
    cur_rst = 1'b1;
    drive(0, 1, 8, 1'b0);
    lock_start();
    m_state = M_MEAS; m_good = 0; m_fault = 1'b1;
    qualify();
    drive(0, 1, 3, 1'b0);
    clear_i = 1'b1;
    cur_fault = 1'b0;
    drive(0, 1, 1, 1'b0);
    clear_i = 1'b0;
    drive(0, 1, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    lock_start();
    drive(200, 5, 1000, 1'b1);
    drive(200, 5, 501, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rst_o !== 1'b1 || ok_o !== 1'b0 || fault_o !== 1'b0 || count_o !== 10'd0) begin
      n_fail++;
      $display("FAIL mid-window reset: got rst=%b ok=%b fault=%b count=%0d want 1/0/0/0",
               rst_o, ok_o, fault_o, count_o);
    end
    rst_i = 1'b0; lock_i = 1'b0;
    cur_rst = 1'b1; cur_fault = 1'b0;
    drive(200, 5, 1200, 1'b0);
    n_tests++;
    if (count_o !== 10'd0) begin
      n_fail++;
      $display("FAIL partial count after reset: got %0d want 0", count_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_tolerance();
    test_drift();
    test_lockloss_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
